// File: rtl/spi_dac_sequencer_pkg.sv
// Shared types and constants for the SPI DAC sequencer: FSM states, default
// DAC command codes and the frame-width derivation.
package spi_dac_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_GAP   = 2'd3
    } seq_state_t;

    localparam logic [7:0] CMD_WRITE_INPUT  = 8'h10;
    localparam logic [7:0] CMD_UPDATE       = 8'h20;
    localparam logic [7:0] CMD_WRITE_UPDATE = 8'h30;

    // A frame is the command field followed by the sample, MSB first.
    function automatic int frame_width(input int cmd_width, input int sample_width);
        return cmd_width + sample_width;
    endfunction

endpackage

// File: rtl/spi_dac_sequencer_fifo.sv
// Synchronous sample FIFO: first-word-fall-through head, occupancy count,
// overflow/underflow-protected push and pop.
module sync_fifo #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/spi_dac_sequencer.sv
// Feeds an SPI master with one {CMD, sample} frame per sample tick, buffering
// samples from the waveform core and flagging underrun, late tick and timeout.
module spi_dac_sequencer
    import spi_dac_sequencer_pkg::*;
#(
    parameter  int CMD_WIDTH      = 8,
    parameter  int SAMPLE_WIDTH   = 16,
    parameter  int FIFO_DEPTH     = 4,
    parameter  int GAP_CYCLES     = 50,
    parameter  int TIMEOUT_CYCLES = 4096,
    localparam int FRAME_WIDTH    = frame_width(CMD_WIDTH, SAMPLE_WIDTH),
    localparam int FIFO_AW        = $clog2(FIFO_DEPTH)
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic [SAMPLE_WIDTH-1:0] S_DATA,
    input  logic                    S_VALID,
    output logic                    S_READY,
    input  logic [CMD_WIDTH-1:0]    CMD,
    input  logic                    SAMPLE_TICK,
    input  logic                    CLEAR,
    output logic                    SPI_ENABLE,
    output logic [7:0]              SPI_LENGTH,
    output logic [FRAME_WIDTH-1:0]  SPI_DATA_TX,
    input  logic                    SPI_DONE,
    input  logic [FRAME_WIDTH-1:0]  SPI_DATA_RX,
    output logic [FRAME_WIDTH-1:0]  RX_DATA,
    output logic [15:0]             FRAME_CNT,
    output logic                    BUSY,
    output logic                    UNDERRUN,
    output logic                    LATE,
    output logic                    TIMEOUT,
    output seq_state_t              DBG_STATE,
    output logic [FIFO_AW:0]        DBG_FIFO_COUNT
);

    localparam int                WD_W     = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int                GAP_W    = $clog2(GAP_CYCLES) + 1;
    localparam logic [WD_W-1:0]   WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

    seq_state_t               state;
    seq_state_t               state_next;
    logic [WD_W-1:0]          wd_cnt;
    logic [GAP_W-1:0]         gap_cnt;
    logic [SAMPLE_WIDTH-1:0]  fifo_head;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     fifo_pop;
    logic                     set_underrun;
    logic                     set_late;
    logic                     set_timeout;
    logic                     done_accept;

    // Sample input handshake: a word transfers on every rising CLK edge where
    // S_VALID and S_READY are both high; S_READY depends only on FIFO fullness,
    // never on S_VALID, and the source must hold S_DATA while S_VALID is high.
    assign S_READY = ~fifo_full;

    sync_fifo #(
        .WIDTH (SAMPLE_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK       (CLK),
        .RESET     (RESET),
        .push      (S_VALID),
        .push_data (S_DATA),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (DBG_FIFO_COUNT)
    );

    assign SPI_LENGTH = 8'(FRAME_WIDTH / 8);
    assign SPI_ENABLE = (state == ST_START);
    assign BUSY       = (state != ST_IDLE);
    assign DBG_STATE  = state;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        fifo_pop     = 1'b0;
        set_underrun = 1'b0;
        set_timeout  = 1'b0;
        done_accept  = 1'b0;
        // Ticks outside IDLE are dropped, not queued.
        set_late     = SAMPLE_TICK && (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (SAMPLE_TICK) begin
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        state_next = ST_START;
                    end else begin
                        set_underrun = 1'b1;
                    end
                end
            end
            ST_START: begin
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (SPI_DONE) begin
                    done_accept = 1'b1;
                    state_next  = ST_GAP;
                end else if (wd_cnt == WD_LAST) begin
                    set_timeout = 1'b1;
                    state_next  = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Watchdog runs from zero on the first WAIT cycle; gap counter from zero on the first GAP cycle.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wd_cnt  <= '0;
            gap_cnt <= '0;
        end else begin
            if (state == ST_START) begin
                wd_cnt <= '0;
            end else if (state == ST_WAIT) begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end
            if (state == ST_GAP) begin
                gap_cnt <= gap_cnt + GAP_W'(1);
            end else begin
                gap_cnt <= '0;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            SPI_DATA_TX <= '0;
            RX_DATA     <= '0;
            FRAME_CNT   <= '0;
        end else begin
            if (fifo_pop) begin
                SPI_DATA_TX <= {CMD, fifo_head};
            end
            if (done_accept) begin
                RX_DATA   <= SPI_DATA_RX;
                FRAME_CNT <= FRAME_CNT + 16'd1;
            end
        end
    end

    // Sticky flags: a set in the same cycle as CLEAR keeps the flag high.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            UNDERRUN <= 1'b0;
            LATE     <= 1'b0;
            TIMEOUT  <= 1'b0;
        end else begin
            UNDERRUN <= set_underrun | (UNDERRUN & ~CLEAR);
            LATE     <= set_late     | (LATE     & ~CLEAR);
            TIMEOUT  <= set_timeout  | (TIMEOUT  & ~CLEAR);
        end
    end

endmodule

// File: tb/tb_spi_dac_sequencer.sv
// Directed bench for spi_dac_sequencer: table of frames, then hand-written
// sequences for underrun, late ticks, timeout, back-pressure and async reset.
module tb_spi_dac_sequencer;
    import spi_dac_sequencer_pkg::*;

    localparam int CW   = 8;
    localparam int SW   = 16;
    localparam int FW   = 24;
    localparam int GAP  = 8;
    localparam int TMO  = 64;
    localparam logic [FW-1:0] RX_XOR = 24'hA5A5A5;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic [SW-1:0] S_DATA = '0;
    logic          S_VALID = 1'b0;
    logic          S_READY;
    logic [CW-1:0] CMD = CMD_WRITE_UPDATE;
    logic          SAMPLE_TICK = 1'b0;
    logic          CLEAR = 1'b0;
    logic          SPI_ENABLE;
    logic [7:0]    SPI_LENGTH;
    logic [FW-1:0] SPI_DATA_TX;
    logic          SPI_DONE = 1'b0;
    logic [FW-1:0] SPI_DATA_RX = '0;
    logic [FW-1:0] RX_DATA;
    logic [15:0]   FRAME_CNT;
    logic          BUSY;
    logic          UNDERRUN;
    logic          LATE;
    logic          TIMEOUT;
    seq_state_t    DBG_STATE;
    logic [2:0]    DBG_FIFO_COUNT;

    always #5 CLK = ~CLK;

    spi_dac_sequencer #(
        .CMD_WIDTH      (CW),
        .SAMPLE_WIDTH   (SW),
        .FIFO_DEPTH     (4),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .S_DATA         (S_DATA),
        .S_VALID        (S_VALID),
        .S_READY        (S_READY),
        .CMD            (CMD),
        .SAMPLE_TICK    (SAMPLE_TICK),
        .CLEAR          (CLEAR),
        .SPI_ENABLE     (SPI_ENABLE),
        .SPI_LENGTH     (SPI_LENGTH),
        .SPI_DATA_TX    (SPI_DATA_TX),
        .SPI_DONE       (SPI_DONE),
        .SPI_DATA_RX    (SPI_DATA_RX),
        .RX_DATA        (RX_DATA),
        .FRAME_CNT      (FRAME_CNT),
        .BUSY           (BUSY),
        .UNDERRUN       (UNDERRUN),
        .LATE           (LATE),
        .TIMEOUT        (TIMEOUT),
        .DBG_STATE      (DBG_STATE),
        .DBG_FIFO_COUNT (DBG_FIFO_COUNT)
    );

    int            checks = 0;
    int            errors = 0;
    int            enable_count = 0;
    bit            spi_model_on = 1'b1;
    logic [FW-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame scoreboard: every SPI_ENABLE must carry the next expected frame.
    initial begin
        forever begin
            @(negedge CLK);
            if (SPI_ENABLE === 1'b1) begin
                enable_count++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: got 0x%0h expected none at %0t", SPI_DATA_TX, $time);
                end else begin
                    check("frame_tx", SPI_DATA_TX, exp_q.pop_front());
                end
            end
        end
    end

    // SPI master model: DONE 40 cycles after ENABLE, readback is the frame XOR a mask.
    initial begin
        logic [FW-1:0] tx;
        forever begin
            @(negedge CLK);
            if (SPI_ENABLE === 1'b1 && spi_model_on) begin
                tx = SPI_DATA_TX;
                repeat (39) @(negedge CLK);
                SPI_DATA_RX = tx ^ RX_XOR;
                SPI_DONE    = 1'b1;
                check("tx_stable", SPI_DATA_TX, tx);
                @(negedge CLK);
                SPI_DONE = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    task automatic do_tick();
        SAMPLE_TICK = 1'b1;
        @(negedge CLK);
        SAMPLE_TICK = 1'b0;
    endtask

    task automatic pulse_clear();
        CLEAR = 1'b1;
        @(negedge CLK);
        CLEAR = 1'b0;
    endtask

    task automatic push_sample(input logic [SW-1:0] d, input logic [FW-1:0] frame);
        int n = 0;
        S_DATA  = d;
        S_VALID = 1'b1;
        while (S_READY !== 1'b1 && n < 500) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 500) begin
            check("push_timeout", 32'(n), 32'(0));
        end
        @(negedge CLK);
        S_VALID = 1'b0;
        exp_q.push_back(frame);
    endtask

    task automatic wait_done();
        int n = 0;
        while (SPI_DONE !== 1'b1 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 200) begin
            check("done_timeout", 32'(n), 32'(0));
        end
    endtask

    typedef struct {
        logic [SW-1:0] sample;
        logic [CW-1:0] cmd;
        logic [FW-1:0] frame;
        logic [15:0]   fc;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int cnt0;
        vecs[0] = '{16'h1234, 8'h30, 24'h301234, 16'd1};
        vecs[1] = '{16'hABCD, 8'h30, 24'h30ABCD, 16'd2};
        vecs[2] = '{16'h0001, 8'h30, 24'h300001, 16'd3};
        vecs[3] = '{16'hFFFF, 8'h10, 24'h10FFFF, 16'd4};
        vecs[4] = '{16'h0000, 8'h20, 24'h200000, 16'd5};

        // Reset values
        repeat (3) @(negedge CLK);
        check("rst_s_ready", S_READY, 1);
        check("rst_busy", BUSY, 0);
        RESET = 1'b0;
        @(negedge CLK);
        check("rst_length", SPI_LENGTH, 3);
        check("rst_enable", SPI_ENABLE, 0);
        check("rst_tx", SPI_DATA_TX, 0);
        check("rst_rx", RX_DATA, 0);
        check("rst_fc", FRAME_CNT, 0);
        check("rst_flags", {UNDERRUN, LATE, TIMEOUT}, 0);
        check("rst_state", DBG_STATE, ST_IDLE);

        // Table-driven frames: three buffered up front, the rest pushed per tick
        for (int i = 0; i < 3; i++) push_sample(vecs[i].sample, vecs[i].frame);
        for (int i = 0; i < 5; i++) begin
            if (i >= 3) push_sample(vecs[i].sample, vecs[i].frame);
            CMD = vecs[i].cmd;
            do_tick();
            check("tick_latency", SPI_ENABLE, 1);
            repeat (199) @(negedge CLK);
            check("table_fc", FRAME_CNT, vecs[i].fc);
            check("table_rx", RX_DATA, vecs[i].frame ^ RX_XOR);
            check("table_idle", BUSY, 0);
        end
        check("table_q_empty", exp_q.size(), 0);
        CMD = CMD_WRITE_UPDATE;

        // Underrun, CLEAR, and set-wins-over-clear
        cnt0 = enable_count;
        do_tick();
        repeat (3) @(negedge CLK);
        check("underrun_set", UNDERRUN, 1);
        check("underrun_no_enable", enable_count, cnt0);
        check("underrun_idle", BUSY, 0);
        SAMPLE_TICK = 1'b1;
        CLEAR       = 1'b1;
        @(negedge CLK);
        SAMPLE_TICK = 1'b0;
        CLEAR       = 1'b0;
        check("underrun_set_wins", UNDERRUN, 1);
        pulse_clear();
        check("underrun_cleared", UNDERRUN, 0);
        check("clear_keeps_fc", FRAME_CNT, 5);

        // Late ticks in WAIT and GAP
        push_sample(16'h1111, {8'h30, 16'h1111});
        push_sample(16'h2222, {8'h30, 16'h2222});
        cnt0 = enable_count;
        do_tick();
        repeat (10) @(negedge CLK);
        check("late_in_wait_state", DBG_STATE, ST_WAIT);
        do_tick();
        check("late_wait", LATE, 1);
        pulse_clear();
        check("late_cleared", LATE, 0);
        wait_done();
        @(negedge CLK);
        check("late_in_gap_state", DBG_STATE, ST_GAP);
        do_tick();
        check("late_gap", LATE, 1);
        check("late_one_frame", enable_count, cnt0 + 1);
        check("late_fc", FRAME_CNT, 6);
        repeat (20) @(negedge CLK);
        check("late_back_idle", DBG_STATE, ST_IDLE);
        check("late_no_extra", enable_count, cnt0 + 1);
        do_tick();
        check("late_next_sent", SPI_ENABLE, 1);
        repeat (60) @(negedge CLK);
        check("late_fc2", FRAME_CNT, 7);
        pulse_clear();

        // Transfer timeout
        spi_model_on = 1'b0;
        push_sample(16'h0BAD, {8'h30, 16'h0BAD});
        do_tick();
        check("tmo_enable", SPI_ENABLE, 1);
        repeat (TMO) @(negedge CLK);
        check("tmo_not_yet", TIMEOUT, 0);
        @(negedge CLK);
        check("tmo_set", TIMEOUT, 1);
        check("tmo_fc", FRAME_CNT, 7);
        check("tmo_in_gap", DBG_STATE, ST_GAP);
        repeat (GAP + 2) @(negedge CLK);
        check("tmo_idle", BUSY, 0);
        spi_model_on = 1'b1;
        pulse_clear();
        check("tmo_cleared", TIMEOUT, 0);

        // Back-pressure with five samples and a depth-4 FIFO
        check("bp_ready_empty", S_READY, 1);
        for (int i = 0; i < 4; i++) push_sample(16'h5000 + 16'(i), {8'h30, 16'h5000 + 16'(i)});
        check("bp_full", S_READY, 0);
        check("bp_count", DBG_FIFO_COUNT, 4);
        S_DATA  = 16'h5004;
        S_VALID = 1'b1;
        repeat (3) @(negedge CLK);
        check("bp_held", S_READY, 0);
        check("bp_count_held", DBG_FIFO_COUNT, 4);
        SAMPLE_TICK = 1'b1;
        @(negedge CLK);
        SAMPLE_TICK = 1'b0;
        check("bp_ready_after_pop", S_READY, 1);
        check("bp_enable", SPI_ENABLE, 1);
        @(negedge CLK);
        S_VALID = 1'b0;
        exp_q.push_back({8'h30, 16'h5004});
        check("bp_count_refill", DBG_FIFO_COUNT, 4);
        for (int i = 0; i < 4; i++) begin
            repeat (200) @(negedge CLK);
            do_tick();
        end
        repeat (200) @(negedge CLK);
        check("bp_fc", FRAME_CNT, 12);
        check("bp_q_empty", exp_q.size(), 0);
        check("bp_fifo_empty", DBG_FIFO_COUNT, 0);

        // Asynchronous reset in mid-WAIT
        spi_model_on = 1'b0;
        push_sample(16'h7777, {8'h30, 16'h7777});
        push_sample(16'h8888, {8'h30, 16'h8888});
        do_tick();
        repeat (10) @(negedge CLK);
        check("arst_in_wait", DBG_STATE, ST_WAIT);
        #2 RESET = 1'b1;
        #1;
        check("arst_busy", BUSY, 0);
        check("arst_tx", SPI_DATA_TX, 0);
        check("arst_rx", RX_DATA, 0);
        check("arst_fc", FRAME_CNT, 0);
        check("arst_ready", S_READY, 1);
        check("arst_count", DBG_FIFO_COUNT, 0);
        exp_q.delete();
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        cnt0 = enable_count;
        do_tick();
        repeat (3) @(negedge CLK);
        check("arst_underrun", UNDERRUN, 1);
        check("arst_no_enable", enable_count, cnt0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
